tick_interval_timer: RTL and testbench

TICK_INTERVAL_TIMER -- requirements
Module: tick_interval_timer

---
 rtl/tick_interval_timer_pkg.sv | 20 ++
 rtl/tit_channel.sv | 87 ++++++++
 rtl/tick_interval_timer.sv | 77 +++++++
 tb/tb_tick_interval_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tick_interval_timer_pkg.sv
// -----------------------------------------------------------------------------
// tick_interval_timer_pkg
// Shared definitions for the tick interval timer:
//   mode_e          - channel operating mode (periodic / one-shot)
//   DEF_NCH         - default number of channels
//   DEF_CW          - default counter / period width
//   DEF_CH0_PERIOD  - default channel-0 period loaded at reset (5 min of 1 us)
// -----------------------------------------------------------------------------
package tick_interval_timer_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    localparam int          DEF_NCH        = 4;
    localparam int          DEF_CW         = 32;
    localparam int unsigned DEF_CH0_PERIOD = 32'd300000000;

endpackage

// File: rtl/tit_channel.sv
// -----------------------------------------------------------------------------
// tit_channel
// One timer channel: holds period, mode, enable and a counter that advances on
// each shared timebase event. At expiry the counter clears and a one-clock
// tick pulse is emitted on the following cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   i_ev      in   shared timebase event (one cycle)
//   i_sync    in   restart counter; coincident event is discarded
//   i_wr      in   configuration write addressed to this channel
//   i_period  in   new period (CW bits)
//   i_mode    in   new mode (0 periodic, 1 one-shot)
//   i_en      in   new enable
//   o_tick    out  registered one-clock expiry pulse
//   o_busy    out  enabled with a nonzero period
// -----------------------------------------------------------------------------
module tit_channel
    import tick_interval_timer_pkg::*;
#(
    parameter int            CW         = DEF_CW,
    parameter logic [CW-1:0] RST_PERIOD = '0,
    parameter logic          RST_EN     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ev,
    input  logic          i_sync,
    input  logic          i_wr,
    input  logic [CW-1:0] i_period,
    input  logic          i_mode,
    input  logic          i_en,
    output logic          o_tick,
    output logic          o_busy
);

    logic [CW-1:0] r_period;
    logic [CW-1:0] r_count;
    mode_e         r_mode;
    logic          r_en;
    logic          r_tick;

    logic          w_busy;
    logic          w_last;
    logic          w_expire;

    // A zero period parks the channel regardless of the enable bit.
    assign w_busy   = r_en && (r_period != '0);
    assign w_last   = (r_count == (r_period - CW'(1)));
    // A configuration write or sync in the event cycle swallows that event.
    assign w_expire = i_ev && w_busy && w_last && !i_wr && !i_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= RST_PERIOD;
            r_mode   <= MODE_PERIODIC;
            r_en     <= RST_EN;
            r_count  <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_expire;
            if (i_wr) begin
                r_period <= i_period;
                r_mode   <= mode_e'(i_mode);
                r_en     <= i_en;
                r_count  <= '0;
            end else if (i_sync) begin
                r_count <= '0;
            end else if (i_ev && w_busy) begin
                if (w_last) begin
                    r_count <= '0;
                    // One-shot disarms at expiry so busy falls with the tick.
                    if (r_mode == MODE_ONESHOT) begin
                        r_en <= 1'b0;
                    end
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign o_tick = r_tick;
    assign o_busy = w_busy;

endmodule

// File: rtl/tick_interval_timer.sv
// -----------------------------------------------------------------------------
// tick_interval_timer
// NCH independent interval timers driven by a shared 1 us timebase. The
// asynchronous t1us input is synchronised through a 3-bit shift register and
// its rising edge becomes a single-cycle event. Configuration writes are
// decoded here and routed to one channel.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   t1us        in   asynchronous 1 us timebase pulse
//   cfg_wr      in   one-cycle configuration write strobe
//   cfg_ch      in   channel index for cfg_wr (indices >= NCH ignored)
//   cfg_period  in   period in timebase events
//   cfg_mode    in   0 periodic, 1 one-shot
//   cfg_en      in   channel enable
//   sync        in   restart all channel counters
//   tick_out    out  one-clock expiry pulse per channel
//   busy        out  channel enabled with nonzero period
// -----------------------------------------------------------------------------
module tick_interval_timer
    import tick_interval_timer_pkg::*;
#(
    parameter int          NCH        = DEF_NCH,
    parameter int          CW         = DEF_CW,
    parameter int unsigned CH0_PERIOD = DEF_CH0_PERIOD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           t1us,
    input  logic           cfg_wr,
    input  logic [3:0]     cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    input  logic           cfg_mode,
    input  logic           cfg_en,
    input  logic           sync,
    output logic [NCH-1:0] tick_out,
    output logic [NCH-1:0] busy
);

    logic [2:0]     r_t1us_sr;
    logic           w_ev;
    logic [NCH-1:0] w_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t1us_sr <= '0;
        end else begin
            r_t1us_sr <= {r_t1us_sr[1:0], t1us};
        end
    end

    // Rising edge seen after two synchroniser stages: exactly one cycle per pulse.
    assign w_ev = (r_t1us_sr == 3'b011);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_wr[gi] = cfg_wr && (cfg_ch == 4'(gi));

        tit_channel #(
            .CW         (CW),
            .RST_PERIOD ((gi == 0) ? CW'(CH0_PERIOD) : {CW{1'b0}}),
            .RST_EN     (gi == 0)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_ev     (w_ev),
            .i_sync   (sync),
            .i_wr     (w_wr[gi]),
            .i_period (cfg_period),
            .i_mode   (cfg_mode),
            .i_en     (cfg_en),
            .o_tick   (tick_out[gi]),
            .o_busy   (busy[gi])
        );
    end

endmodule

// File: tb/tb_tick_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_tick_interval_timer
// Directed bench for tick_interval_timer with NCH=4, CW=16, CH0_PERIOD=5.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at the same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_tick_interval_timer;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic           clk        = 1'b0;
    logic           rst        = 1'b1;
    logic           t1us       = 1'b0;
    logic           cfg_wr     = 1'b0;
    logic [3:0]     cfg_ch     = '0;
    logic [CW-1:0]  cfg_period = '0;
    logic           cfg_mode   = 1'b0;
    logic           cfg_en     = 1'b0;
    logic           sync       = 1'b0;
    logic [NCH-1:0] tick_out;
    logic [NCH-1:0] busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_tick [NCH];

    // Snapshots taken inside ev(): right after the event-driven update, and one clock later.
    logic [NCH-1:0] tk_at;
    logic [NCH-1:0] tk_after;
    logic [NCH-1:0] bz_at;
    int             base;

    tick_interval_timer #(
        .NCH        (NCH),
        .CW         (CW),
        .CH0_PERIOD (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .t1us       (t1us),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .cfg_en     (cfg_en),
        .sync       (sync),
        .tick_out   (tick_out),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- tick counter ----------------
    always @(negedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (tick_out[i] === 1'b1) n_tick[i]++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input logic [3:0] ch, input logic [CW-1:0] per,
                              input logic mode, input logic en);
        cfg_ch     = ch;
        cfg_period = per;
        cfg_mode   = mode;
        cfg_en     = en;
    endtask

    task automatic cfg(input logic [3:0] ch, input logic [CW-1:0] per,
                       input logic mode, input logic en);
        set_fields(ch, per, mode, en);
        cfg_wr = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    // One t1us pulse, 10 clocks high / 10 low. The event cycle is the one
    // after the second step; inj=1 adds cfg_wr there, inj=2 adds sync.
    task automatic ev(input int inj);
        t1us = 1'b1;
        step();
        step();
        if (inj == 1) cfg_wr = 1'b1;
        if (inj == 2) sync   = 1'b1;
        step();
        cfg_wr   = 1'b0;
        sync     = 1'b0;
        tk_at    = tick_out;
        bz_at    = busy;
        step();
        tk_after = tick_out;
        repeat (6) step();
        t1us = 1'b0;
        repeat (10) step();
    endtask

    // ---------------- stimulus + checks ----------------
    initial begin
        repeat (3) step();
        rst = 1'b0;
        check("reset_tick", 32'(tick_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h1);

        // ch0 at reset period 5: tick on every 5th event, 1 clk wide
        for (int k = 1; k <= 10; k++) begin
            ev(0);
            check($sformatf("ch0_p5_ev%0d", k), 32'(tk_at[0]), 32'((k % 5) == 0));
            if ((k % 5) == 0) begin
                check($sformatf("ch0_p5_width%0d", k), 32'(tk_after[0]), 32'h0);
                check($sformatf("others_quiet%0d", k), 32'(tk_at[3:1]), 32'h0);
            end
        end

        // ch1 one-shot period 3
        cfg(4'd1, 16'd3, 1'b1, 1'b1);
        check("ch1_busy_cfg", 32'(busy[1]), 32'h1);
        base = n_tick[1];
        for (int k = 1; k <= 3; k++) begin
            ev(0);
            check($sformatf("ch1_os_tick%0d", k), 32'(tk_at[1]), 32'(k == 3));
            check($sformatf("ch1_os_busy%0d", k), 32'(bz_at[1]), 32'(k != 3));
        end
        repeat (20) ev(0);
        check("ch1_os_total", 32'(n_tick[1] - base), 32'd1);
        check("ch1_os_idle", 32'(busy[1]), 32'h0);

        // ch2 period 1 then period 0
        cfg(4'd2, 16'd1, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            ev(0);
            check($sformatf("ch2_p1_tick%0d", k), 32'(tk_at[2]), 32'h1);
            check($sformatf("ch2_p1_width%0d", k), 32'(tk_after[2]), 32'h0);
        end
        cfg(4'd2, 16'd0, 1'b0, 1'b1);
        check("ch2_p0_busy", 32'(busy[2]), 32'h0);
        base = n_tick[2];
        repeat (3) ev(0);
        check("ch2_p0_ticks", 32'(n_tick[2] - base), 32'd0);

        // sync mid-interval, then sync coinciding with an event
        cfg(4'd0, 16'd4, 1'b0, 1'b1);
        ev(0);
        ev(0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ev(0);
            check($sformatf("sync_restart%0d", k), 32'(tk_at[0]), 32'(k == 4));
        end
        ev(0);
        ev(0);
        ev(2);
        check("sync_ev_tick", 32'(tk_at[0]), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            ev(0);
            check($sformatf("sync_ev_drop%0d", k), 32'(tk_at[0]), 32'(k == 4));
        end

        // cfg_wr in the expiry event cycle wins; out-of-range writes ignored
        cfg(4'd0, 16'd4, 1'b0, 1'b1);
        repeat (3) ev(0);
        set_fields(4'd0, 16'd4, 1'b0, 1'b1);
        ev(1);
        check("wr_ev_tick", 32'(tk_at[0]), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            ev(0);
            check($sformatf("wr_ev_restart%0d", k), 32'(tk_at[0]), 32'(k == 4));
        end
        cfg(4'd4, 16'd1, 1'b0, 1'b1);
        check("bad_ch4_busy", 32'(busy), 32'h1);
        cfg(4'd15, 16'd1, 1'b1, 1'b1);
        check("bad_ch15_busy", 32'(busy), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            ev(0);
            check($sformatf("bad_ch_ch0_%0d", k), 32'(tk_at[0]), 32'(k == 4));
        end

        // sync together with a cfg_wr to ch3
        ev(0);
        set_fields(4'd3, 16'd2, 1'b0, 1'b1);
        cfg_wr = 1'b1;
        sync   = 1'b1;
        step();
        cfg_wr = 1'b0;
        sync   = 1'b0;
        check("sync_wr_busy", 32'(busy), 32'h9);
        for (int k = 1; k <= 4; k++) begin
            ev(0);
            check($sformatf("sync_wr_ch0_%0d", k), 32'(tk_at[0]), 32'(k == 4));
            check($sformatf("sync_wr_ch3_%0d", k), 32'(tk_at[3]), 32'((k % 2) == 0));
        end

        // reset mid-interval: count 3 of period 5
        cfg(4'd0, 16'd5, 1'b0, 1'b1);
        repeat (3) ev(0);
        base = n_tick[0];
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_tick", 32'(tick_out), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h1);
        for (int k = 1; k <= 10; k++) begin
            ev(0);
            check($sformatf("rst_restart%0d", k), 32'(tk_at[0]), 32'((k % 5) == 0));
        end
        check("rst_total", 32'(n_tick[0] - base), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
